// File: rtl/io_port_pkg.sv
// Shared definitions for the io_port GPIO block: register word addresses.
package io_port_pkg;

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_EVENT   = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN  = 3'd6;

endpackage

// File: rtl/io_sync.sv
// Per-bit two-flop synchronizer for asynchronous pin inputs.
module io_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: flops use non-blocking assignments so both stages sample the old values on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/io_port.sv
// Memory-mapped GPIO port: output/direction registers, synchronized inputs,
// edge-detect event latches with write-1-to-clear, and a registered interrupt.
module io_port
    import io_port_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PORT_WIDTH = 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [2:0]            i_Addr,
    input  logic                  i_WrEnable,
    input  logic [DATA_WIDTH-1:0] i_WrData,
    output logic [DATA_WIDTH-1:0] o_RdData,
    input  logic [PORT_WIDTH-1:0] i_PinIn,
    output logic [PORT_WIDTH-1:0] o_PinOut,
    output logic [PORT_WIDTH-1:0] o_PinOe,
    output logic                  o_Irq
);

    logic [PORT_WIDTH-1:0] out_q,     out_d;
    logic [PORT_WIDTH-1:0] dir_q,     dir_d;
    logic [PORT_WIDTH-1:0] event_q,   event_d;
    logic [PORT_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [PORT_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [PORT_WIDTH-1:0] irq_en_q,  irq_en_d;
    logic [PORT_WIDTH-1:0] prev_q,    prev_d;
    logic                  irq_q,     irq_d;

    logic [PORT_WIDTH-1:0] in_sync;
    logic [PORT_WIDTH-1:0] wr_val;
    logic [PORT_WIDTH-1:0] rise;
    logic [PORT_WIDTH-1:0] fall;
    logic [PORT_WIDTH-1:0] set_mask;
    logic [PORT_WIDTH-1:0] clr_mask;
    logic [PORT_WIDTH-1:0] rd_val;
    logic                  unused_wr_data;

    io_sync #(
        .WIDTH (PORT_WIDTH)
    ) u_sync (
        .clk   (i_Clock),
        .rst_n (i_Reset),
        .d     (i_PinIn),
        .q     (in_sync)
    );

    // Upper write-data bits beyond the pin count carry no meaning here.
    assign unused_wr_data = ^{1'b0, i_WrData};
    assign wr_val         = i_WrData[PORT_WIDTH-1:0];

    assign rise     = in_sync & ~prev_q;
    assign fall     = ~in_sync & prev_q;
    assign set_mask = (rise & rise_en_q) | (fall & fall_en_q);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        clr_mask  = '0;
        if (i_WrEnable) begin
            case (i_Addr)
                ADDR_OUT:     out_d     = wr_val;
                ADDR_DIR:     dir_d     = wr_val;
                ADDR_EVENT:   clr_mask  = wr_val;
                ADDR_RISE_EN: rise_en_d = wr_val;
                ADDR_FALL_EN: fall_en_d = wr_val;
                ADDR_IRQ_EN:  irq_en_d  = wr_val;
                default:      ;
            endcase
        end
        // A new edge on the same cycle as a clear keeps the bit set.
        event_d = (event_q & ~clr_mask) | set_mask;
        prev_d  = in_sync;
        irq_d   = |(event_q & irq_en_q);
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            event_q   <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_en_q  <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            event_q   <= event_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_en_q  <= irq_en_d;
            prev_q    <= prev_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rd_val = '0;
        case (i_Addr)
            ADDR_OUT:     rd_val = out_q;
            ADDR_DIR:     rd_val = dir_q;
            ADDR_IN:      rd_val = in_sync;
            ADDR_EVENT:   rd_val = event_q;
            ADDR_RISE_EN: rd_val = rise_en_q;
            ADDR_FALL_EN: rd_val = fall_en_q;
            ADDR_IRQ_EN:  rd_val = irq_en_q;
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        o_RdData                 = '0;
        o_RdData[PORT_WIDTH-1:0] = rd_val;
    end

    assign o_PinOut = out_q;
    assign o_PinOe  = dir_q;
    assign o_Irq    = irq_q;

endmodule

// File: tb/tb_io_port.sv
// Directed self-checking bench for io_port with DATA_WIDTH=32, PORT_WIDTH=8.
module tb_io_port;
    import io_port_pkg::*;

    logic        i_Clock;
    logic        i_Reset;
    logic [2:0]  i_Addr;
    logic        i_WrEnable;
    logic [31:0] i_WrData;
    logic [31:0] o_RdData;
    logic [7:0]  i_PinIn;
    logic [7:0]  o_PinOut;
    logic [7:0]  o_PinOe;
    logic        o_Irq;

    int checks   = 0;
    int failures = 0;

    io_port #(
        .DATA_WIDTH (32),
        .PORT_WIDTH (8)
    ) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Addr     (i_Addr),
        .i_WrEnable (i_WrEnable),
        .i_WrData   (i_WrData),
        .o_RdData   (o_RdData),
        .i_PinIn    (i_PinIn),
        .o_PinOut   (o_PinOut),
        .o_PinOe    (o_PinOe),
        .o_Irq      (o_Irq)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; the write lands on the next posedge, return at the following negedge.
    task automatic write_reg(input logic [2:0] addr, input logic [31:0] data);
        i_Addr     = addr;
        i_WrData   = data;
        i_WrEnable = 1'b1;
        @(negedge i_Clock);
        i_WrEnable = 1'b0;
        i_WrData   = '0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        i_Addr = addr;
        #1;
        check(tag, o_RdData, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge i_Clock);
    endtask

    initial begin
        i_Reset    = 1'b0;
        i_Addr     = '0;
        i_WrEnable = 1'b0;
        i_WrData   = '0;
        i_PinIn    = 8'hFF;

        // Reset held with pins high
        cycles(3);
        check("rst_pinoe",  {24'h0, o_PinOe},  32'h0);
        check("rst_pinout", {24'h0, o_PinOut}, 32'h0);
        check("rst_irq",    {31'h0, o_Irq},    32'h0);
        check_reg("rst_in",    ADDR_IN,    32'h0);
        check_reg("rst_event", ADDR_EVENT, 32'h0);
        check_reg("rst_out",   ADDR_OUT,   32'h0);

        // Release: IN follows pins after two edges
        i_Reset = 1'b1;
        cycles(1);
        check_reg("in_after1", ADDR_IN, 32'h0);
        cycles(1);
        check_reg("in_after2", ADDR_IN, 32'h0000_00FF);
        cycles(2);
        check_reg("event_post_rst", ADDR_EVENT, 32'h0);
        check("irq_post_rst", {31'h0, o_Irq}, 32'h0);

        // Output and direction
        write_reg(ADDR_DIR, 32'h0000_000F);
        check("pinoe", {24'h0, o_PinOe}, 32'h0000_000F);
        write_reg(ADDR_OUT, 32'h0000_00A5);
        check("pinout", {24'h0, o_PinOut}, 32'h0000_00A5);
        check_reg("rd_dir", ADDR_DIR, 32'h0000_000F);
        check_reg("rd_out", ADDR_OUT, 32'h0000_00A5);
        write_reg(ADDR_OUT, 32'hFFFF_FF5A);
        check_reg("rd_out_zext", ADDR_OUT, 32'h0000_005A);

        // Rising edge on pin0
        i_PinIn = 8'hFE;
        cycles(4);
        check_reg("event_no_en", ADDR_EVENT, 32'h0);
        write_reg(ADDR_RISE_EN, 32'h01);
        write_reg(ADDR_IRQ_EN,  32'h01);
        i_PinIn = 8'hFF;            // changes before edge k
        cycles(1);                  // after k
        check_reg("rise_in_k", ADDR_IN, 32'h0000_00FE);
        cycles(1);                  // after k+1
        check_reg("rise_in_k1", ADDR_IN, 32'h0000_00FF);
        check_reg("rise_ev_k1", ADDR_EVENT, 32'h0);
        cycles(1);                  // after k+2
        check_reg("rise_ev_k2", ADDR_EVENT, 32'h01);
        check("rise_irq_k2", {31'h0, o_Irq}, 32'h0);
        cycles(1);                  // after k+3
        check("rise_irq_k3", {31'h0, o_Irq}, 32'h1);

        // Clear it, IRQ drops one cycle later
        write_reg(ADDR_EVENT, 32'h01);
        check_reg("clr_ev", ADDR_EVENT, 32'h0);
        check("clr_irq_lag", {31'h0, o_Irq}, 32'h1);
        cycles(1);
        check("clr_irq", {31'h0, o_Irq}, 32'h0);

        // Falling pin0 with only rise enabled: no event
        i_PinIn = 8'hFE;
        cycles(4);
        check_reg("fall_no_ev", ADDR_EVENT, 32'h0);

        // Build EVENT=03 then W1C
        i_PinIn = 8'hFC;
        cycles(4);
        write_reg(ADDR_RISE_EN, 32'h03);
        check_reg("rise_en_no_ev", ADDR_EVENT, 32'h0);
        i_PinIn = 8'hFF;
        cycles(4);
        check_reg("ev03", ADDR_EVENT, 32'h03);
        check("ev03_irq", {31'h0, o_Irq}, 32'h1);
        write_reg(ADDR_EVENT, 32'h01);
        check_reg("w1c_bit0", ADDR_EVENT, 32'h02);
        check("w1c_irq_lag", {31'h0, o_Irq}, 32'h1);
        cycles(1);
        check("w1c_irq", {31'h0, o_Irq}, 32'h0);
        write_reg(ADDR_EVENT, 32'h00);
        check_reg("w0_nochg", ADDR_EVENT, 32'h02);

        // Collision: W1C bit1 on the edge its fall event sets
        write_reg(ADDR_RISE_EN, 32'h00);
        write_reg(ADDR_FALL_EN, 32'h02);
        write_reg(ADDR_EVENT,   32'h02);
        check_reg("pre_coll_ev", ADDR_EVENT, 32'h0);
        i_PinIn = 8'hFD;            // before edge k
        cycles(2);                  // after k+1
        check_reg("coll_pre", ADDR_EVENT, 32'h0);
        write_reg(ADDR_EVENT, 32'h02);  // write on edge k+2
        check_reg("coll_set_wins", ADDR_EVENT, 32'h02);

        // Writes to IN and reserved are ignored
        write_reg(ADDR_IN, 32'hFFFF_FFFF);
        write_reg(3'd7,    32'hFFFF_FFFF);
        check_reg("ro_out",     ADDR_OUT,     32'h0000_005A);
        check_reg("ro_dir",     ADDR_DIR,     32'h0000_000F);
        check_reg("ro_in",      ADDR_IN,      32'h0000_00FD);
        check_reg("ro_event",   ADDR_EVENT,   32'h02);
        check_reg("ro_rise_en", ADDR_RISE_EN, 32'h00);
        check_reg("ro_fall_en", ADDR_FALL_EN, 32'h02);
        check_reg("ro_irq_en",  ADDR_IRQ_EN,  32'h01);
        check_reg("rd_rsvd",    3'd7,         32'h0);

        // Reset asserted mid-write discards the write
        i_Addr     = ADDR_OUT;
        i_WrData   = 32'h0000_00FF;
        i_WrEnable = 1'b1;
        #2 i_Reset = 1'b0;
        #1;
        check("rst_async_out", {24'h0, o_PinOut}, 32'h0);
        check("rst_async_oe",  {24'h0, o_PinOe},  32'h0);
        @(negedge i_Clock);
        i_WrEnable = 1'b0;
        check("rst_midwr_out", {24'h0, o_PinOut}, 32'h0);
        check_reg("rst_midwr_ev", ADDR_EVENT, 32'h0);
        i_Reset = 1'b1;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
